updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised synchronous up/down counter. It is the next generation of the team's 4-bit x-controlled up/down counter.
- Adds configurable width, modulus and step size, wrap or saturate mode, enable, synchronous clear, parallel load, and terminal-count/overflow/underflow flags.
- Intended as the standard counting primitive for sequential-logic lab designs: timers, position trackers, event tallies.
- Uses an external clock input. There is no internal clock generator.

Parameters:
- WIDTH, 4: count register width in bits. Must be ≥ 1.
- MAX_VAL, 2**WIDTH-1: highest count value; the modulus is MAX_VAL+1. Must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- STEP, 1: increment/decrement amount per enabled cycle. Must satisfy 1 ≤ STEP ≤ MAX_VAL.
- SATURATE, 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.

Ports:
- clk  input  1  sole clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable. When low, count holds unless clr or load is asserted.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  registered count.
- tc  output  1  terminal count (combinational from count and up).
- ovf  output  1  registered one-cycle pulse: an increment crossed or hit the top limit.
- unf  output  1  registered one-cycle pulse: a decrement crossed or hit the bottom limit.

Behaviour:
- Reset (rst=1, asynchronous): count=0, ovf=0, unf=0 immediately, independent of clk. On release, counting resumes at the first posedge with rst=0.
- Reset mid-operation forces the same values at once; there is no pending-operation memory.
- Priority per posedge: rst > clr > load > en. Exactly one action occurs per edge.
- clr=1: count←0; ovf=unf=0.
- load=1 (clr=0): count←min(load_val, MAX_VAL); ovf=unf=0. An out-of-range load_val is clamped, never wrapped.
- en=1, up=1, wrap mode:
  - if count+STEP > MAX_VAL: count←count+STEP−(MAX_VAL+1) and ovf=1;
  - otherwise count←count+STEP.
- en=1, up=0, wrap mode:
  - if count < STEP: count←count+(MAX_VAL+1)−STEP and unf=1;
  - otherwise count←count−STEP.
- Saturate mode:
  - increment clamps to MAX_VAL; decrement clamps to 0.
  - ovf pulses when an increment is attempted with count+STEP > MAX_VAL, including when already at MAX_VAL (sticky-at-limit gives a repeated pulse every enabled cycle).
  - unf mirrors this at 0.
- en=0 with no clr/load: count holds; ovf=unf=0.
- Latency: one cycle from input sample to count/ovf/unf update. ovf/unf assert in the same cycle as the wrapped or clamped count.
- tc = up ? (count==MAX_VAL) : (count==0). It is combinational, with no dependency on en.
- Arithmetic:
  - Compute next value in WIDTH+1 bits so count+STEP never overflows silently.
  - Compare against MAX_VAL as WIDTH+1 unsigned.
  - Truncate to WIDTH only after the wrap/clamp decision.
- Illegal parameter combinations (MAX_VAL or STEP out of range) are rejected at elaboration time with a fatal message.
- Default parameters (WIDTH=4, MAX_VAL=15, STEP=1, SATURATE=0) reproduce the legacy sequence exactly: 0 up→1, 15 up→0, 0 down→15.

Decomposition:
- Shared package counter_pkg:
  - mode constants CNT_MODE_WRAP=0, CNT_MODE_SAT=1;
  - direction constants CNT_DIR_UP=1, CNT_DIR_DOWN=0.
- One natural sub-module: counter_next_calc. It is purely combinational: inputs count, up, and parameters; outputs next_count, ovf_next, unf_next.
- The top level holds the register, priority mux and tc.

Test Plan:
- Reset: hold rst=1 mid-count (count=9), asserted between edges → count=0 immediately, ovf=unf=0; release, en=1, up=1 → 1,2,3 on successive edges.
- Default wrap: load 14, en=1, up=1 → 15 (tc=1), then 0 with ovf=1 for exactly one cycle. From 0 with up=0 → 15 with unf=1.
- Modulus/step: MAX_VAL=9, STEP=3, load 8, up=1 → 1 with ovf=1. From 1, up=0 → 8 with unf=1.
- Saturate: SATURATE=1, MAX_VAL=9, load 8, STEP=1, up=1 for 3 edges → 9, 9, 9, with ovf=0,1,1 respectively. From 0, up=0 → 0 with unf=1.
- Priority: clr=1, load=1, load_val=5, en=1 same edge → count=0. Next edge load=1, clr=0 → 5. load_val=12 with MAX_VAL=9 → 9.
- Hold: en=0, up toggling for 5 edges → count unchanged, ovf=unf=0; tc follows up at count=0 (up=0 → tc=1, up=1 → tc=0).

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the counter family: counting mode and direction encodings.
package counter_pkg;

  typedef enum logic {
    CNT_MODE_WRAP = 1'b0,
    CNT_MODE_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    CNT_DIR_DOWN = 1'b0,
    CNT_DIR_UP   = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count for one enabled step: wrap or clamp, plus limit flags.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_next,
  output logic             unf_next
);

  localparam cnt_mode_e      MODE   = (SATURATE != 0) ? CNT_MODE_SAT : CNT_MODE_WRAP;
  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_X  = MAX_X + (WIDTH+1)'(1);

  // One guard bit so count+STEP and count+MOD never overflow before the decision.
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] res_x;

  assign cnt_x = {1'b0, count};

  always_comb begin
    res_x    = cnt_x;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (cnt_dir_e'(up) == CNT_DIR_UP) begin
      if (cnt_x + STEP_X > MAX_X) begin
        ovf_next = 1'b1;
        res_x    = (MODE == CNT_MODE_SAT) ? MAX_X : cnt_x + STEP_X - MOD_X;
      end else begin
        res_x = cnt_x + STEP_X;
      end
    end else begin
      if (cnt_x < STEP_X) begin
        unf_next = 1'b1;
        res_x    = (MODE == CNT_MODE_SAT) ? '0 : cnt_x + MOD_X - STEP_X;
      end else begin
        res_x = cnt_x - STEP_X;
      end
    end
    next_count = res_x[WIDTH-1:0];
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: register, clr > load > en priority, and terminal count.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "updown_counter_param: WIDTH must be >= 1");
  end
  if (MAX_VAL < 1 || 64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $fatal(1, "updown_counter_param: MAX_VAL must be in 1 .. 2**WIDTH-1");
  end
  if (STEP < 1 || STEP > MAX_VAL) begin : g_bad_step
    $fatal(1, "updown_counter_param: STEP must be in 1 .. MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] step_count;
  logic             step_ovf, step_unf;
  logic [WIDTH-1:0] load_clamped;

  counter_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP),
    .SATURATE(SATURATE)
  ) u_next (
    .count     (count_q),
    .up        (up),
    .next_count(step_count),
    .ovf_next  (step_ovf),
    .unf_next  (step_unf)
  );

  // Out-of-range loads clamp to the top value rather than wrapping.
  assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = step_count;
      ovf_d   = step_ovf;
      unf_d   = step_unf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign tc    = (cnt_dir_e'(up) == CNT_DIR_UP) ? (count_q == MAX_W) : (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counter configurations share stimulus, each tracked by an arithmetic model.
module tb_updown_counter_param;

  localparam int N = 3;
  localparam int MAXV [N] = '{15, 9, 9};
  localparam int STP  [N] = '{1, 3, 1};
  localparam int SAT  [N] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       rst, en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt [N];
  logic       tc  [N];
  logic       ovf [N];
  logic       unf [N];

  int m_cnt [N];
  int m_ovf [N];
  int m_unf [N];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4)) d0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[0]), .tc(tc[0]), .ovf(ovf[0]), .unf(unf[0])
  );
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(0)) d1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[1]), .tc(tc[1]), .ovf(ovf[1]), .unf(unf[1])
  );
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1)) d2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(cnt[2]), .tc(tc[2]), .ovf(ovf[2]), .unf(unf[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
      m_unf[i] = 0;
    end
  endfunction

  // Reference: plain integer arithmetic on the counting rules.
  function automatic void model_step();
    int t;
    for (int i = 0; i < N; i++) begin
      m_ovf[i] = 0;
      m_unf[i] = 0;
      if (rst) begin
        m_cnt[i] = 0;
      end else if (clr) begin
        m_cnt[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
      end else if (en) begin
        if (up) begin
          t = m_cnt[i] + STP[i];
          if (t > MAXV[i]) begin
            m_ovf[i] = 1;
            t = SAT[i] ? MAXV[i] : t - (MAXV[i] + 1);
          end
        end else begin
          t = m_cnt[i] - STP[i];
          if (t < 0) begin
            m_unf[i] = 1;
            t = SAT[i] ? 0 : t + MAXV[i] + 1;
          end
        end
        m_cnt[i] = t;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    int exp_tc;
    for (int i = 0; i < N; i++) begin
      exp_tc = up ? int'(m_cnt[i] == MAXV[i]) : int'(m_cnt[i] == 0);
      chk($sformatf("%s.d%0d.count", tag, i), 32'(cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("%s.d%0d.ovf", tag, i), 32'(ovf[i]), 32'(m_ovf[i]));
      chk($sformatf("%s.d%0d.unf", tag, i), 32'(unf[i]), 32'(m_unf[i]));
      chk($sformatf("%s.d%0d.tc", tag, i), 32'(tc[i]), 32'(exp_tc));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic c, input logic l, input int lv, input logic e, input logic u);
    clr      = c;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    up       = u;
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_all("reset");
    #3;
    rst = 1'b0;

    drive(0, 0, 0, 1, 1);
    tick("up1");
    drive(0, 1, 9, 0, 1);
    tick("load9");
    async_reset("rst_mid");
    drive(0, 0, 0, 1, 1);
    repeat (3) tick("post_rst_up");

    drive(0, 1, 14, 0, 1);
    tick("load14");
    drive(0, 0, 0, 1, 1);
    tick("to_top");
    tick("wrap_up");
    tick("ovf_one_cycle");
    drive(1, 0, 0, 0, 1);
    tick("clr");
    drive(0, 0, 0, 1, 0);
    tick("wrap_down");

    drive(0, 1, 8, 0, 1);
    tick("load8");
    drive(0, 0, 0, 1, 1);
    repeat (3) tick("sat_up");
    drive(0, 0, 0, 1, 0);
    tick("step_down");
    drive(1, 0, 0, 0, 0);
    tick("clr2");
    drive(0, 0, 0, 1, 0);
    tick("sat_down");

    drive(1, 1, 5, 1, 1);
    tick("prio_clr");
    drive(0, 1, 5, 1, 1);
    tick("prio_load");
    drive(0, 1, 12, 0, 1);
    tick("load_clamp");

    drive(1, 0, 0, 0, 0);
    tick("clr3");
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, k[0]);
      #1;
      check_all("hold_tc");
      tick("hold");
    end

    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      tick("rand");
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
